// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and load/store ports onto one memory with a one-cycle registered read.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_arbiter #(
  parameter int mem_width = 32,
  parameter int mem_depth = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 f_req,
  input  logic [31:0]          f_addr,
  output logic                 f_gnt,
  output logic                 f_rvalid,
  output logic [31:0]          f_rdata,
  output logic                 f_err,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [31:0]          d_addr,
  input  logic [1:0]           d_size,
  input  logic                 d_unsigned,
  input  logic [31:0]          d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [31:0]          d_rdata,
  output logic                 d_err,
  output logic                 mem_r_en,
  output logic [mem_width-1:0] mem_r_addr,
  output logic                 mem_w_en,
  output logic [mem_width-3:0] mem_w_addr,
  output logic [mem_width-1:0] mem_w_data,
  output logic [3:0]           mem_w_mask,
  input  logic [mem_width-1:0] mem_r_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic                   cmd_fetch_q, cmd_fetch_d;
  logic                   cmd_we_q, cmd_we_d;
  logic [1:0]             cmd_size_q, cmd_size_d;
  logic                   cmd_uns_q, cmd_uns_d;
  logic [1:0]             cmd_off_q, cmd_off_d;
  logic                   cmd_err_q, cmd_err_d;
  logic                   mem_r_en_q, mem_r_en_d;
  logic [mem_width-1:0]   mem_r_addr_q, mem_r_addr_d;
  logic                   mem_w_en_q, mem_w_en_d;
  logic [mem_width-3:0]   mem_w_addr_q, mem_w_addr_d;
  logic [mem_width-1:0]   mem_w_data_q, mem_w_data_d;
  logic [3:0]             mem_w_mask_q, mem_w_mask_d;
  logic                   f_rvalid_q, f_rvalid_d, f_err_q, f_err_d;
  logic                   d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
  logic [31:0]            f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;

  logic                   grant_s, pick_data_s, legal_s, align_ok_s, range_ok_s, sel_we_s;
  logic [31:0]            sel_addr_s;
  logic [1:0]             sel_size_s;
  logic [31:0]            st_data_s;
  logic [3:0]             st_mask_s;
  logic [7:0]             lane_b_s;
  logic [15:0]            lane_h_s;
  logic [31:0]            fmt_s, resp_data_s;

  assign grant_s = (state_q == IDLE) && (f_req || d_req);

`ifdef MEM_ARB_RR_EN
  logic last_fetch_q, last_fetch_d;

  // Round-robin pick: on contention the port not granted last wins
  always_comb begin
    pick_data_s = d_req && (!f_req || last_fetch_q);
    if (grant_s) begin
      last_fetch_d = !pick_data_s;
    end else begin
      last_fetch_d = last_fetch_q;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_fetch_q <= 1'b1;
    end else begin
      last_fetch_q <= last_fetch_d;
    end
  end
`else
  assign pick_data_s = d_req;
`endif

  // Gated by rst_n so no grant is visible while reset is held
  assign d_gnt = rst_n & grant_s & pick_data_s;
  assign f_gnt = rst_n & grant_s & ~pick_data_s;

  // Winning request and its legality; fetches behave as aligned word reads
  always_comb begin
    sel_addr_s = pick_data_s ? d_addr : f_addr;
    sel_size_s = pick_data_s ? d_size : 2'd2;
    sel_we_s   = pick_data_s & d_we;
    range_ok_s = ({2'b00, sel_addr_s[31:2]} < 32'(mem_depth));
    case (sel_size_s)
      2'd0:    align_ok_s = 1'b1;
      2'd1:    align_ok_s = ~sel_addr_s[0];
      2'd2:    align_ok_s = (sel_addr_s[1:0] == 2'b00);
      default: align_ok_s = 1'b0;
    endcase
    legal_s = range_ok_s & align_ok_s;
  end

  // Store lane replication and byte mask
  always_comb begin
    case (d_size)
      2'd0: begin
        st_data_s = {4{d_wdata[7:0]}};
        st_mask_s = 4'b0001 << d_addr[1:0];
      end
      2'd1: begin
        st_data_s = {2{d_wdata[15:0]}};
        st_mask_s = 4'b0011 << {d_addr[1], 1'b0};
      end
      default: begin
        st_data_s = d_wdata;
        st_mask_s = 4'b1111;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    case (cmd_off_q)
      2'd0:    lane_b_s = mem_r_data[7:0];
      2'd1:    lane_b_s = mem_r_data[15:8];
      2'd2:    lane_b_s = mem_r_data[23:16];
      default: lane_b_s = mem_r_data[31:24];
    endcase
    lane_h_s = cmd_off_q[1] ? mem_r_data[31:16] : mem_r_data[15:0];
    case (cmd_size_q)
      2'd0:    fmt_s = cmd_uns_q ? {24'd0, lane_b_s} : {{24{lane_b_s[7]}}, lane_b_s};
      2'd1:    fmt_s = cmd_uns_q ? {16'd0, lane_h_s} : {{16{lane_h_s[15]}}, lane_h_s};
      default: fmt_s = mem_r_data;
    endcase
    resp_data_s = (cmd_err_q || cmd_we_q) ? 32'd0 : fmt_s;
  end

  // Next state; the memory command registers are only loaded on a grant, so they live for exactly the ACCESS cycle
  always_comb begin
    state_d      = state_q;
    cmd_fetch_d  = cmd_fetch_q;
    cmd_we_d     = cmd_we_q;
    cmd_size_d   = cmd_size_q;
    cmd_uns_d    = cmd_uns_q;
    cmd_off_d    = cmd_off_q;
    cmd_err_d    = cmd_err_q;
    mem_r_en_d   = 1'b0;
    mem_r_addr_d = '0;
    mem_w_en_d   = 1'b0;
    mem_w_addr_d = '0;
    mem_w_data_d = '0;
    mem_w_mask_d = 4'b0000;
    f_rvalid_d   = 1'b0;
    f_rdata_d    = f_rdata_q;
    f_err_d      = f_err_q;
    d_rvalid_d   = 1'b0;
    d_rdata_d    = d_rdata_q;
    d_err_d      = d_err_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          state_d     = ACCESS;
          cmd_fetch_d = ~pick_data_s;
          cmd_we_d    = sel_we_s;
          cmd_size_d  = sel_size_s;
          cmd_uns_d   = pick_data_s & d_unsigned;
          cmd_off_d   = sel_addr_s[1:0];
          cmd_err_d   = ~legal_s;
          if (legal_s && sel_we_s) begin
            mem_w_en_d   = 1'b1;
            mem_w_addr_d = sel_addr_s[31:2];
            mem_w_data_d = st_data_s;
            mem_w_mask_d = st_mask_s;
          end else if (legal_s) begin
            mem_r_en_d   = 1'b1;
            mem_r_addr_d = mem_width'(sel_addr_s[31:2]);
          end else begin
            mem_r_en_d   = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        if (cmd_fetch_q) begin
          f_rvalid_d = 1'b1;
          f_rdata_d  = resp_data_s;
          f_err_d    = cmd_err_q;
        end else begin
          d_rvalid_d = 1'b1;
          d_rdata_d  = resp_data_s;
          d_err_d    = cmd_err_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, command and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_fetch_q  <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_size_q   <= 2'd0;
      cmd_uns_q    <= 1'b0;
      cmd_off_q    <= 2'd0;
      cmd_err_q    <= 1'b0;
      mem_r_en_q   <= 1'b0;
      mem_r_addr_q <= '0;
      mem_w_en_q   <= 1'b0;
      mem_w_addr_q <= '0;
      mem_w_data_q <= '0;
      mem_w_mask_q <= 4'b0000;
      f_rvalid_q   <= 1'b0;
      f_rdata_q    <= 32'd0;
      f_err_q      <= 1'b0;
      d_rvalid_q   <= 1'b0;
      d_rdata_q    <= 32'd0;
      d_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_fetch_q  <= cmd_fetch_d;
      cmd_we_q     <= cmd_we_d;
      cmd_size_q   <= cmd_size_d;
      cmd_uns_q    <= cmd_uns_d;
      cmd_off_q    <= cmd_off_d;
      cmd_err_q    <= cmd_err_d;
      mem_r_en_q   <= mem_r_en_d;
      mem_r_addr_q <= mem_r_addr_d;
      mem_w_en_q   <= mem_w_en_d;
      mem_w_addr_q <= mem_w_addr_d;
      mem_w_data_q <= mem_w_data_d;
      mem_w_mask_q <= mem_w_mask_d;
      f_rvalid_q   <= f_rvalid_d;
      f_rdata_q    <= f_rdata_d;
      f_err_q      <= f_err_d;
      d_rvalid_q   <= d_rvalid_d;
      d_rdata_q    <= d_rdata_d;
      d_err_q      <= d_err_d;
    end
  end

  assign mem_r_en   = mem_r_en_q;
  assign mem_r_addr = mem_r_addr_q;
  assign mem_w_en   = mem_w_en_q;
  assign mem_w_addr = mem_w_addr_q;
  assign mem_w_data = mem_w_data_q;
  assign mem_w_mask = mem_w_mask_q;
  assign f_rvalid   = f_rvalid_q;
  assign f_rdata    = f_rdata_q;
  assign f_err      = f_err_q;
  assign d_rvalid   = d_rvalid_q;
  assign d_rdata    = d_rdata_q;
  assign d_err      = d_err_q;

endmodule
